seg_glyph_drawer: RTL and testbench
===================================

Name: seg_glyph_drawer

Overview:
- Parametrised successor to the per-digit glyph drawers.
- Draws any hex glyph 0–F as a seven-segment figure. Emits one pixel coordinate per step to the VGA plotter, using a valid/ready handshake.
- The caller supplies the glyph origin, digit, colour and an erase mode; the block raises busy, streams pixels, then pulses done.
- Sits between the board/tile controller and the vga_adapter write port.

Parameters:
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- COLOUR_W, 3, colour width
- H_LEN, 7, horizontal segment length in pixels (>=2)
- V_LEN, 7, vertical segment length in pixels (>=2)
- X_OFF, 8, glyph left edge relative to x_base
- Y_OFF, 7, glyph top edge relative to y_base

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- start  in  1  request to draw; sampled only while busy=0
- digit  in  4  hex value 0–F to draw
- erase  in  1  1 = draw all seven segments in colour_in, ignoring digit (tile blanking)
- x_base  in  X_W  tile origin x
- y_base  in  Y_W  tile origin y
- colour_in  in  COLOUR_W  pixel colour
- ready  in  1  plotter accepts the current pixel
- x_out  out  X_W  pixel x, registered
- y_out  out  Y_W  pixel y, registered
- colour_out  out  COLOUR_W  pixel colour, registered
- plot  out  1  pixel valid, registered
- busy  out  1  drawing in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (resetn=0 at posedge, including mid-draw):
  - state=IDLE; plot=busy=done=0; x_out=y_out=colour_out=0.
  - All internal counters cleared. Any in-progress glyph is abandoned.
- Reset is the only way to abort a draw.
- Segment index order: 0=a(top), 1=b(upper right), 2=c(lower right), 3=d(bottom), 4=e(lower left), 5=f(upper left), 6=g(middle). Mask bit i enables segment i.
- Mask table, hex 0–F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71. erase=1 forces mask=7F.
- Geometry: X0=X_OFF, X1=X_OFF+H_LEN-1, Y0=Y_OFF, Y1=Y_OFF+V_LEN-1, Y2=Y_OFF+2*(V_LEN-1).
  - a: y=Y0, x=X0..X1
  - g: y=Y1, x=X0..X1
  - d: y=Y2, x=X0..X1
  - f: x=X0, y=Y0..Y1
  - b: x=X1, y=Y0..Y1
  - e: x=X0, y=Y1..Y2
  - c: x=X1, y=Y1..Y2
- Pixel order: horizontal segments left→right, vertical segments top→bottom. Shared corner pixels are emitted once per segment, i.e. duplicates are allowed.
- Output coordinates: x_out=(x_base+offset) mod 2^X_W and y_out=(y_base+offset) mod 2^Y_W. Wrap-around is silent.
- FSM states: IDLE, DRAW, FIN.
  - IDLE: on edge E0 with start=1, latch digit/erase/base/colour, compute mask, busy<=1, seg=0, pix=0, go to DRAW.
  - DRAW, step rules on each edge:
    - Segment seg disabled: plot<=0, seg advances. This is exactly one skip cycle per disabled segment.
    - Segment enabled and no pixel pending (plot=0, or plot=1 with ready=1): register the next pixel with plot<=1.
    - Pixel pending (plot=1, ready=0): hold x_out/y_out/colour_out/plot/counters unchanged.
    - pix wraps to 0 after the segment's last pixel and seg advances.
    - After the last pixel of segment g is accepted (or g is skipped), go to FIN.
  - FIN: one edge; plot<=0, busy<=0, done<=1, then IDLE. done is high for exactly one cycle.
- Throughput: with ready tied high, plot is high for (enabled segments × length) cycles, plus one plot=0 cycle per disabled segment.
- Latency: first pixel (or skip) appears after E1.
- start while busy=1 is ignored; inputs other than ready and resetn are not sampled during a draw.
- start in the same cycle as done=1 is accepted (state is already IDLE).

Test Plan:
- Digit 8, base (0,0), ready=1 → 49 plot cycles with no gaps. First pixel (8,7); segment a ends (14,7); last pixel (14,13) from g. done exactly 1 cycle after the final plot. busy high E0..FIN.
- Digit 1, base (10,20) → E1 plot=0 (a skipped); E2 pixel (24,27) … (24,33) for b; c (24,33)..(24,39); then 4 skip cycles; 14 pixels total.
- Digit 1 again with ready toggled 0/1 every cycle → same 14 coordinates in the same order. Each pixel is held while ready=0, and no pixel is lost or duplicated.
- erase=1 with digit=1, colour 3'b000 → 49 pixels identical in position to digit 8, all with colour_out=0.
- x_base=250, y_base=120, digit 7 → x wraps (250+14=8 mod 256); y wraps (120+19=11 mod 128). Verify against the mod formula.
- resetn=0 during the 10th pixel of digit 8 → next cycle all outputs are 0 and state is IDLE. A new start then draws digit 0 fully (42 pixels + 1 skip). A start pulsed during busy is ignored.

Source files
------------

// File: rtl/seg_glyph_drawer.sv
// Seven-segment hex glyph drawer: walks the enabled segments of a digit and
// streams one pixel per handshake to the VGA plotter, then pulses done.
module seg_glyph_drawer #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int H_LEN    = 7,
  parameter int V_LEN    = 7,
  parameter int X_OFF    = 8,
  parameter int Y_OFF    = 7
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [3:0]          digit,
  input  logic                erase,
  input  logic [X_W-1:0]      x_base,
  input  logic [Y_W-1:0]      y_base,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                ready,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

  localparam int L_MAX = (H_LEN > V_LEN) ? H_LEN : V_LEN;
  localparam int PIX_W = $clog2(L_MAX);

  localparam logic [X_W-1:0]   X0     = X_W'(X_OFF);
  localparam logic [X_W-1:0]   X1     = X_W'(X_OFF + H_LEN - 1);
  localparam logic [Y_W-1:0]   Y0     = Y_W'(Y_OFF);
  localparam logic [Y_W-1:0]   Y1     = Y_W'(Y_OFF + V_LEN - 1);
  localparam logic [Y_W-1:0]   Y2     = Y_W'(Y_OFF + 2 * (V_LEN - 1));
  localparam logic [PIX_W-1:0] H_LAST = PIX_W'(H_LEN - 1);
  localparam logic [PIX_W-1:0] V_LAST = PIX_W'(V_LEN - 1);

  localparam logic [2:0] SEG_A = 3'd0, SEG_B = 3'd1, SEG_C = 3'd2, SEG_D = 3'd3;
  localparam logic [2:0] SEG_E = 3'd4, SEG_F = 3'd5, SEG_G = 3'd6;

  function automatic logic [6:0] glyph_mask(input logic [3:0] d);
    case (d)
      4'h0: glyph_mask = 7'h3F;
      4'h1: glyph_mask = 7'h06;
      4'h2: glyph_mask = 7'h5B;
      4'h3: glyph_mask = 7'h4F;
      4'h4: glyph_mask = 7'h66;
      4'h5: glyph_mask = 7'h6D;
      4'h6: glyph_mask = 7'h7D;
      4'h7: glyph_mask = 7'h07;
      4'h8: glyph_mask = 7'h7F;
      4'h9: glyph_mask = 7'h6F;
      4'hA: glyph_mask = 7'h77;
      4'hB: glyph_mask = 7'h7C;
      4'hC: glyph_mask = 7'h39;
      4'hD: glyph_mask = 7'h5E;
      4'hE: glyph_mask = 7'h79;
      default: glyph_mask = 7'h71;
    endcase
  endfunction

  state_t                state_q, state_d;
  logic [2:0]            seg_q, seg_d;
  logic [PIX_W-1:0]      pix_q, pix_d;
  logic [6:0]            mask_q, mask_d;
  logic [X_W-1:0]        xb_q, xb_d;
  logic [Y_W-1:0]        yb_q, yb_d;
  logic [COLOUR_W-1:0]   col_q, col_d;
  logic [X_W-1:0]        x_out_q, x_out_d;
  logic [Y_W-1:0]        y_out_q, y_out_d;
  logic [COLOUR_W-1:0]   colour_out_q, colour_out_d;
  logic                  plot_q, plot_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [X_W-1:0] off_x;
  logic [Y_W-1:0] off_y;
  logic           seg_last_pix;
  logic           pending;

  always_comb begin
    state_d      = state_q;
    seg_d        = seg_q;
    pix_d        = pix_q;
    mask_d       = mask_q;
    xb_d         = xb_q;
    yb_d         = yb_q;
    col_d        = col_q;
    x_out_d      = x_out_q;
    y_out_d      = y_out_q;
    colour_out_d = colour_out_q;
    plot_d       = plot_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    off_x        = X0 + X_W'(pix_q);
    off_y        = Y0;
    // Pixel offset inside the glyph for the current segment/step.
    case (seg_q)
      SEG_A: begin off_x = X0 + X_W'(pix_q); off_y = Y0;                 end
      SEG_B: begin off_x = X1;                off_y = Y0 + Y_W'(pix_q);  end
      SEG_C: begin off_x = X1;                off_y = Y1 + Y_W'(pix_q);  end
      SEG_D: begin off_x = X0 + X_W'(pix_q); off_y = Y2;                 end
      SEG_E: begin off_x = X0;                off_y = Y1 + Y_W'(pix_q);  end
      SEG_F: begin off_x = X0;                off_y = Y0 + Y_W'(pix_q);  end
      default: begin off_x = X0 + X_W'(pix_q); off_y = Y1;               end
    endcase
    seg_last_pix = (seg_q == SEG_A || seg_q == SEG_D || seg_q == SEG_G) ?
                   (pix_q == H_LAST) : (pix_q == V_LAST);
    pending      = plot_q && !ready;

    case (state_q)
      IDLE: begin
        plot_d = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          mask_d  = erase ? 7'h7F : glyph_mask(digit);
          xb_d    = x_base;
          yb_d    = y_base;
          col_d   = colour_in;
          seg_d   = SEG_A;
          pix_d   = '0;
          busy_d  = 1'b1;
          state_d = DRAW;
        end
      end
      DRAW: begin
        // A pixel the plotter has not taken yet blocks every other step.
        if (!pending) begin
          if (!mask_q[seg_q]) begin
            plot_d = 1'b0;
            if (seg_q == SEG_G) state_d = FIN;
            else                seg_d   = seg_q + 3'd1;
          end else begin
            x_out_d      = xb_q + off_x;
            y_out_d      = yb_q + off_y;
            colour_out_d = col_q;
            plot_d       = 1'b1;
            if (seg_last_pix) begin
              pix_d = '0;
              if (seg_q == SEG_G) state_d = FIN;
              else                seg_d   = seg_q + 3'd1;
            end else begin
              pix_d = pix_q + PIX_W'(1);
            end
          end
        end
      end
      FIN: begin
        // Waits here only while the final pixel of g is still unaccepted.
        if (!pending) begin
          plot_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          seg_d   = SEG_A;
          pix_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      seg_q        <= '0;
      pix_q        <= '0;
      mask_q       <= '0;
      xb_q         <= '0;
      yb_q         <= '0;
      col_q        <= '0;
      x_out_q      <= '0;
      y_out_q      <= '0;
      colour_out_q <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      seg_q        <= seg_d;
      pix_q        <= pix_d;
      mask_q       <= mask_d;
      xb_q         <= xb_d;
      yb_q         <= yb_d;
      col_q        <= col_d;
      x_out_q      <= x_out_d;
      y_out_q      <= y_out_d;
      colour_out_q <= colour_out_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign colour_out = colour_out_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_seg_glyph_drawer.sv
// Bench for seg_glyph_drawer: stimulus pushes expected pixels into a queue,
// an independent monitor pops and compares every accepted pixel.
module tb_seg_glyph_drawer;

  logic       clk = 1'b0;
  logic       resetn, start, erase, ready;
  logic [3:0] digit;
  logic [7:0] x_base;
  logic [6:0] y_base;
  logic [2:0] colour_in;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot, busy, done;

  always #5 clk = ~clk;

  seg_glyph_drawer #(
    .X_W(8), .Y_W(7), .COLOUR_W(3), .H_LEN(7), .V_LEN(7), .X_OFF(8), .Y_OFF(7)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .digit(digit), .erase(erase),
    .x_base(x_base), .y_base(y_base), .colour_in(colour_in), .ready(ready),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
    .plot(plot), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t       sb[$];
  pix_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         n_acc_r;
  bit         found;
  logic [6:0] mtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_x"}, int'(x_out), 0);
    chk({tag, "_y"}, int'(y_out), 0);
    chk({tag, "_colour"}, int'(colour_out), 0);
    chk({tag, "_plot"}, int'(plot), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  // Expected glyph pixels: X0=8, X1=14, Y0=7, Y1=13, Y2=19, all segments 7 long.
  task automatic push_glyph(input logic [3:0] dg, input logic er, input logic [7:0] xb,
                            input logic [6:0] yb, input logic [2:0] col);
    logic [6:0] m;
    int         ox, oy;
    pix_t       p;
    m = er ? 7'h7F : mtab[dg];
    for (int s = 0; s < 7; s++) begin
      if (m[s]) begin
        for (int k = 0; k < 7; k++) begin
          case (s)
            0:       begin ox = 8 + k; oy = 7;      end
            1:       begin ox = 14;    oy = 7 + k;  end
            2:       begin ox = 14;    oy = 13 + k; end
            3:       begin ox = 8 + k; oy = 19;     end
            4:       begin ox = 8;     oy = 13 + k; end
            5:       begin ox = 8;     oy = 7 + k;  end
            default: begin ox = 8 + k; oy = 13;     end
          endcase
          p.x = 8'((int'(xb) + ox) % 256);
          p.y = 7'((int'(yb) + oy) % 128);
          p.c = col;
          sb.push_back(p);
        end
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (resetn && plot && ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pixel_extra: actual=(%0d,%0d,c%0d) required=none", x_out, y_out, colour_out);
      end else begin
        mon_e = sb.pop_front();
        if ({x_out, y_out, colour_out} != mon_e) begin
          errors++;
          $display("FAIL pixel: actual=(%0d,%0d,c%0d) required=(%0d,%0d,c%0d)",
                   x_out, y_out, colour_out, mon_e.x, mon_e.y, mon_e.c);
        end
      end
    end
  end

  // Called and left at posedge+1.
  task automatic run_draw(input string tag, input logic [3:0] dg, input logic er,
                          input logic [7:0] xb, input logic [6:0] yb, input logic [2:0] col,
                          input bit tog, input bit poke, input int e_acc, input int e_skip,
                          input bit e_lastplot, input int fx, input int fy,
                          input int lx, input int ly);
    int n_acc, n_skip, n_busy_low, f_x, f_y, l_x, l_y;
    bit prev_plot, got_done;
    push_glyph(dg, er, xb, yb, col);
    n_acc = 0; n_skip = 0; n_busy_low = 0; prev_plot = 0; got_done = 0;
    f_x = -1; f_y = -1; l_x = -1; l_y = -1;
    ready = 1'b1;
    digit = dg; erase = er; x_base = xb; y_base = yb; colour_in = col; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    digit = ~dg; erase = ~er; x_base = 8'hAA; y_base = 7'h55; colour_in = ~col;
    chk({tag, "_busy_e0"}, int'(busy), 1);
    for (int n = 0; n < 400 && !got_done; n++) begin
      @(posedge clk); #1;
      if (tog) ready = ~ready;
      start = (poke && n == 5);
      @(negedge clk);
      if (done) begin
        got_done = 1;
        chk({tag, "_busy_at_done"}, int'(busy), 0);
        chk({tag, "_plot_before_done"}, int'(prev_plot), int'(e_lastplot));
      end else begin
        if (plot && ready) begin
          if (n_acc == 0) begin f_x = x_out; f_y = y_out; end
          l_x = x_out; l_y = y_out;
          n_acc++;
        end
        if (!plot) n_skip++;
        if (!busy) n_busy_low++;
        prev_plot = plot;
      end
    end
    chk({tag, "_done_seen"}, int'(got_done), 1);
    chk({tag, "_accepted"}, n_acc, e_acc);
    chk({tag, "_skips"}, n_skip, e_skip);
    chk({tag, "_busy_gap"}, n_busy_low, 0);
    chk({tag, "_first_x"}, f_x, fx);
    chk({tag, "_first_y"}, f_y, fy);
    chk({tag, "_last_x"}, l_x, lx);
    chk({tag, "_last_y"}, l_y, ly);
    chk({tag, "_sb_left"}, sb.size(), 0);
    @(posedge clk); #1;
    ready = 1'b1; start = 1'b0;
    @(negedge clk);
    chk({tag, "_done_1cyc"}, int'(done), 0);
    chk({tag, "_idle_busy"}, int'(busy), 0);
    sb.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; digit = '0; erase = 1'b0;
    x_base = '0; y_base = '0; colour_in = '0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    resetn = 1'b1;
    @(posedge clk); #1;

    run_draw("d8",     4'h8, 1'b0, 8'd0,   7'd0,   3'b101, 0, 0, 49, 0, 1, 8, 7,   14, 13);
    run_draw("d1",     4'h1, 1'b0, 8'd10,  7'd20,  3'b110, 0, 0, 14, 5, 0, 24, 27, 24, 39);
    run_draw("d1_tog", 4'h1, 1'b0, 8'd10,  7'd20,  3'b011, 1, 0, 14, 5, 0, 24, 27, 24, 39);
    run_draw("erase",  4'h1, 1'b1, 8'd0,   7'd0,   3'b000, 0, 0, 49, 0, 1, 8, 7,   14, 13);
    run_draw("wrap",   4'h7, 1'b0, 8'd250, 7'd120, 3'b111, 0, 0, 21, 4, 0, 2, 127, 8,  11);

    // Abort digit 8 while its 10th pixel is on the outputs.
    push_glyph(4'h8, 1'b0, 8'd0, 7'd0, 3'b010);
    digit = 4'h8; erase = 1'b0; x_base = 8'd0; y_base = 7'd0; colour_in = 3'b010;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0; n_acc_r = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (plot && ready) n_acc_r++;
      @(posedge clk); #1;
      if (n_acc_r == 9 && plot) begin found = 1; break; end
    end
    chk("rst_mid_found", int'(found), 1);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk_idle("rst_mid");
    resetn = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_abandon_busy", int'(busy), 0);
    chk("rst_abandon_plot", int'(plot), 0);

    run_draw("d0_poke", 4'h0, 1'b0, 8'd0, 7'd0, 3'b001, 0, 1, 42, 1, 0, 8, 7, 8, 13);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
